// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl
// ---------------------------------------------------------------------------
// Data-memory controller for the MEM stage. One CPU word load/store of DATA_W
// bits becomes BEATS = DATA_W/DQ_W narrower SRAM beats. Each beat lasts
// WAIT_CYC+1 cycles. The pipeline is frozen through `ready` until the access
// completes. Misaligned and out-of-range addresses are rejected with a
// one-cycle addr_err pulse, and a rejected access never touches the SRAM.
//
// Request/ready semantics: MEM_R_EN/MEM_W_EN (with ALU_Res/Val_Rm) form a
// request that the CPU holds stable until it sees ready=1. ready is high in
// the single cycle where the result is available (DONE or ERR). The request
// is consumed at the clock edge that ends that cycle. A request still present
// after that edge is a new request. It is accepted one IDLE cycle later.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   MEM_W_EN        store request (wins if both enables are high)
//   MEM_R_EN        load request; also gates `out`
//   ALU_Res         CPU byte address
//   Val_Rm          store data
//   out             load data register when MEM_R_EN=1, else 0
//   ready           low = stall pipeline
//   addr_err        high during the single ERR cycle
//   SRAM_*          asynchronous SRAM bus; all strobes active-low
//   state_dbg       current FSM state (0 idle, 1 access, 2 done, 3 err)
module sram_word_ctrl #(
  parameter int          DATA_W    = 32,
  parameter int          DQ_W      = 16,
  parameter int          SRAM_AW   = 18,
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          WAIT_CYC  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_W_EN,
  input  logic               MEM_R_EN,
  input  logic [31:0]        ALU_Res,
  input  logic [DATA_W-1:0]  Val_Rm,
  output logic [DATA_W-1:0]  out,
  output logic               ready,
  output logic               addr_err,
  inout  wire  [DQ_W-1:0]    SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic [1:0]         state_dbg
);

  localparam int BEATS    = DATA_W / DQ_W;
  localparam int BYTES    = DATA_W / 8;
  localparam int BEAT_LSB = $clog2(BEATS);
  localparam int BYTE_LSB = $clog2(BYTES);
  localparam int BW       = (BEATS > 1) ? BEAT_LSB : 1;
  // Byte span covered by the SRAM. The compare is done in 64 bits so that a
  // full 32-bit span does not overflow.
  localparam logic [63:0]   SPAN      = 64'(2 ** SRAM_AW) * 64'(DQ_W / 8);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [3:0]    LAST_WAIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 req;
  logic                 is_err;
  logic [31:0]          off;
  logic [SRAM_AW-1:0]   base_addr;
  logic [SRAM_AW-1:0]   addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W-1:0]    shadow_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [DATA_W-1:0]    assembled;
  logic                 wr_q;
  logic [BW-1:0]        b_q;
  logic [3:0]           w_q;
  logic                 beat_end;
  logic                 in_access;
  logic [DQ_W-1:0]      dq_out;

  assign req  = MEM_R_EN | MEM_W_EN;
  // Negative offsets wrap to huge values and fail the range test as well.
  assign off       = ALU_Res - BASE_ADDR;
  assign is_err    = ((off & 32'(BYTES - 1)) != 32'd0) || ({32'd0, off} >= SPAN);
  assign base_addr = SRAM_AW'((off >> BYTE_LSB) << BEAT_LSB);
  assign beat_end  = (w_q == LAST_WAIT);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req) state_d = is_err ? S_ERR : S_ACCESS;
      S_ACCESS: if (beat_end && (b_q == LAST_BEAT)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // The current read beat is merged into the lanes captured so far. The
  // visible data register changes only when the last beat lands, so a load
  // replaces the data register in one step.
  always_comb begin
    assembled = shadow_q;
    assembled[int'(b_q) * DQ_W +: DQ_W] = SRAM_DQ;
  end

  // Datapath: latched request, beat/wait counters, read capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
      b_q      <= '0;
      w_q      <= '0;
    end else if (state_q == S_IDLE) begin
      if (req && !is_err) begin
        addr_q  <= base_addr;
        wdata_q <= Val_Rm;
        wr_q    <= MEM_W_EN;
        b_q     <= '0;
        w_q     <= '0;
      end else if (req && !MEM_W_EN) begin
        // A rejected load completes with zero data.
        rdata_q <= '0;
      end
    end else if (state_q == S_ACCESS) begin
      if (beat_end) begin
        w_q <= '0;
        b_q <= (b_q == LAST_BEAT) ? '0 : b_q + 1'b1;
        if (!wr_q) begin
          shadow_q <= assembled;
          if (b_q == LAST_BEAT) rdata_q <= assembled;
        end
      end else begin
        w_q <= w_q + 4'd1;
      end
    end
  end

  // Outputs
  always_comb begin
    in_access = (state_q == S_ACCESS);
    SRAM_CE_N = ~in_access;
    SRAM_UB_N = ~in_access;
    SRAM_LB_N = ~in_access;
    SRAM_WE_N = ~(in_access & wr_q);
    SRAM_OE_N = ~(in_access & ~wr_q);
    SRAM_ADDR = in_access ? (addr_q + SRAM_AW'(b_q)) : '0;
    dq_out    = wdata_q[int'(b_q) * DQ_W +: DQ_W];
    addr_err  = (state_q == S_ERR);
    ready     = ~(req & (state_q != S_DONE) & (state_q != S_ERR));
    out       = MEM_R_EN ? rdata_q : '0;
    state_dbg = state_q;
  end

  // The DQ drive comes from the same term as WE_N, so both release on one edge.
  assign SRAM_DQ = (in_access && wr_q) ? dq_out : {DQ_W{1'bz}};

endmodule

// File: tb/tb_sram_word_ctrl.sv
// tb_sram_word_ctrl
// ---------------------------------------------------------------------------
// Three controller instances share one clock:
//   inst 0: DATA_W=32, WAIT_CYC=1
//   inst 1: DATA_W=64, WAIT_CYC=0
//   inst 2: DATA_W=32, WAIT_CYC=3
// Each instance has its own behavioural SRAM. The SRAM only returns true data
// on the last cycle of every beat and returns corrupted data on the others.
// The reference model works on whole CPU words (an associative array keyed by
// word index) plus the last completed load per instance.
module tb_sram_word_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        r_en [3];
  logic        w_en [3];
  logic [31:0] alu  [3];
  logic [63:0] val  [3];

  wire [63:0] out_w   [3];
  wire        ready_w [3];
  wire        err_w   [3];
  wire        we_w    [3];
  wire        oe_w    [3];
  wire        ce_w    [3];
  wire        ub_w    [3];
  wire        lb_w    [3];
  wire [17:0] sa_w    [3];
  wire [1:0]  st_w    [3];

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] ref_mem [int];
  logic [63:0] last_rd [3];

  // ---------------- DUTs + SRAM models ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DW = (g == 1) ? 64 : 32;
    localparam int WC = (g == 1) ? 0 : ((g == 2) ? 3 : 1);
    wire [15:0]   dq;
    wire [DW-1:0] out_loc;
    bit  [15:0]   mem [0:262143];
    int           cyc = 0;

    sram_word_ctrl #(
      .DATA_W(DW), .DQ_W(16), .SRAM_AW(18), .BASE_ADDR(32'd1024), .WAIT_CYC(WC)
    ) u_dut (
      .clk(clk), .rst(rst_n),
      .MEM_W_EN(w_en[g]), .MEM_R_EN(r_en[g]),
      .ALU_Res(alu[g]), .Val_Rm(val[g][DW-1:0]),
      .out(out_loc), .ready(ready_w[g]), .addr_err(err_w[g]),
      .SRAM_DQ(dq), .SRAM_ADDR(sa_w[g]),
      .SRAM_WE_N(we_w[g]), .SRAM_OE_N(oe_w[g]), .SRAM_CE_N(ce_w[g]),
      .SRAM_UB_N(ub_w[g]), .SRAM_LB_N(lb_w[g]),
      .state_dbg(st_w[g])
    );

    assign out_w[g] = 64'(out_loc);

    // cyc counts cycles since CE_N fell; only the last cycle of a beat is valid.
    assign dq = (!oe_w[g] && !ce_w[g])
              ? (((cyc % (WC + 1)) == WC) ? mem[sa_w[g]] : (mem[sa_w[g]] ^ 16'hA5A5))
              : 16'bz;

    always @(posedge clk) begin
      cyc <= ce_w[g] ? 0 : cyc + 1;
      if (!ce_w[g] && !we_w[g]) mem[sa_w[g]] <= dq;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int beats_of(input int inst);
    return (inst == 1) ? 4 : 2;
  endfunction

  function automatic int wc_of(input int inst);
    return (inst == 1) ? 0 : ((inst == 2) ? 3 : 1);
  endfunction

  function automatic logic [15:0] mem_rd(input int inst, input int a);
    logic [15:0] v;
    case (inst)
      0:       v = g_dut[0].mem[a];
      1:       v = g_dut[1].mem[a];
      default: v = g_dut[2].mem[a];
    endcase
    return v;
  endfunction

  // One complete CPU access on instance `inst`. With keep=1 the request stays
  // up after completion, so the next call sees the IDLE turnaround cycle.
  task automatic access(input int inst, input bit wr, input bit rd,
                        input logic [31:0] addr, input logic [63:0] data,
                        input bit keep);
    int beats, wc, bytes, n, lat, ecyc, key;
    int ce_lo, we_lo, oe_lo, bad_addr, bad_lane;
    bit err;
    logic [31:0] off, idx;
    logic [63:0] d, exp_out;
    beats = beats_of(inst);
    wc    = wc_of(inst);
    bytes = beats * 2;
    d     = (inst == 1) ? data : {32'd0, data[31:0]};
    off   = addr - 32'd1024;
    err   = ((off % 32'(bytes)) != 32'd0) || (off >= 32'd524288);
    idx   = off / 32'(bytes);
    key   = err ? -1 : inst * (1 << 20) + int'(idx);
    lat   = err ? 1 : beats * (wc + 1) + 1;
    ecyc  = err ? 0 : beats * (wc + 1);

    @(negedge clk);
    r_en[inst] = rd; w_en[inst] = wr; alu[inst] = addr; val[inst] = d;
    #1 check("ready_low_on_request", 64'(ready_w[inst]), 64'd0);

    n = 0; ce_lo = 0; we_lo = 0; oe_lo = 0; bad_addr = 0; bad_lane = 0;
    while (n < 64) begin
      @(negedge clk);
      n++;
      if (!ce_w[inst]) begin
        ce_lo++;
        if (sa_w[inst] !== 18'(int'(idx) * beats + (n - 1) / (wc + 1))) bad_addr++;
      end
      if (!we_w[inst]) we_lo++;
      if (!oe_w[inst]) oe_lo++;
      if (ub_w[inst] !== ce_w[inst] || lb_w[inst] !== ce_w[inst]) bad_lane++;
      if (ready_w[inst]) break;
    end

    if (!wr) last_rd[inst] = err ? 64'd0 : (ref_mem.exists(key) ? ref_mem[key] : 64'd0);
    if (wr && !err) ref_mem[key] = d;
    exp_out = rd ? last_rd[inst] : 64'd0;

    check("latency", 64'(n), 64'(lat));
    check("addr_err", 64'(err_w[inst]), 64'(err));
    check("out", out_w[inst], exp_out);
    check("ce_cycles", 64'(ce_lo), 64'(ecyc));
    check("we_cycles", 64'(we_lo), wr ? 64'(ecyc) : 64'd0);
    check("oe_cycles", 64'(oe_lo), wr ? 64'd0 : 64'(ecyc));
    check("beat_addr", 64'(bad_addr), 64'd0);
    check("ub_lb", 64'(bad_lane), 64'd0);
    if (wr && !err)
      for (int k = 0; k < beats; k++)
        check("sram_lane", 64'(mem_rd(inst, int'(idx) * beats + k)), 64'(d[k*16 +: 16]));

    if (!keep) begin
      r_en[inst] = 1'b0; w_en[inst] = 1'b0;
      @(negedge clk);
      check("idle_ready", 64'(ready_w[inst]), 64'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int inst, mode, op, bytes;
    logic [31:0] a;
    logic [63:0] d;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r_en[i] = 1'b0; w_en[i] = 1'b0; alu[i] = '0; val[i] = '0; last_rd[i] = '0;
    end
    r_en[0] = 1'b1;
    #12;
    // Reset state: a load request during reset sees a zero data register.
    check("rst_out", out_w[0], 64'd0);
    check("rst_ready", 64'(ready_w[0]), 64'd0);
    check("rst_state", 64'(st_w[0]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("rst_strobes", {59'd0, ce_w[i], we_w[i], oe_w[i], ub_w[i], lb_w[i]}, 64'h1F);
      check("rst_addr", 64'(sa_w[i]), 64'd0);
      check("rst_err", 64'(err_w[i]), 64'd0);
    end
    r_en[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic store/load at the base address.
    access(0, 1, 0, 32'd1024, 64'hDEADBEEF, 0);
    access(0, 0, 1, 32'd1024, 64'd0, 0);
    // Top word of the SRAM, then a read back.
    access(0, 1, 0, 32'd1024 + 32'd4 * 32'd131071, 64'h5A5A1234, 0);
    access(0, 0, 1, 32'd1024 + 32'd4 * 32'd131071, 64'd0, 0);
    // Rejected accesses: past the end, below the base, misaligned.
    access(0, 0, 1, 32'd1024 + 32'd4 * 32'd131072, 64'd0, 0);
    access(0, 1, 0, 32'd1020, 64'h11112222, 0);
    access(0, 0, 1, 32'd1026, 64'd0, 0);

    // 64-bit instance, zero wait states.
    access(1, 1, 0, 32'd1032, 64'h0123456789ABCDEF, 0);
    access(1, 0, 1, 32'd1032, 64'd0, 0);

    // Reset asserted during beat 1 of a write.
    @(negedge clk);
    w_en[0] = 1'b1; alu[0] = 32'd1032; val[0] = 64'hCAFEF00D;
    repeat (3) @(negedge clk);
    check("mid_write_we", 64'(we_w[0]), 64'd0);
    check("mid_write_addr", 64'(sa_w[0]), 64'd5);
    rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", {59'd0, ce_w[0], we_w[0], oe_w[0], ub_w[0], lb_w[0]}, 64'h1F);
    check("rst_mid_addr", 64'(sa_w[0]), 64'd0);
    w_en[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    check("rst_lane0_written", 64'(mem_rd(0, 4)), 64'hF00D);
    check("rst_lane1_unwritten", 64'(mem_rd(0, 5)), 64'd0);
    ref_mem[2] = 64'h0000F00D;
    access(0, 0, 1, 32'd1032, 64'd0, 0);

    // Both enables high: a write; the following load returns the store data.
    d = 64'($urandom);
    access(0, 1, 1, 32'd1040, d, 0);
    access(0, 0, 1, 32'd1040, 64'd0, 0);

    // Long wait states: corrupted DQ on non-sampling cycles must not leak.
    for (int i = 0; i < 3; i++) begin
      a = 32'd1024 + 32'd4 * 32'($urandom_range(0, 63));
      access(2, 1, 0, a, 64'($urandom), 0);
      access(2, 0, 1, a, 64'd0, 0);
    end

    // Back-to-back: request held across DONE.
    access(0, 1, 0, 32'd1048, 64'h600DF00D, 1);
    access(0, 0, 1, 32'd1048, 64'd0, 0);

    // Randomized mix across instances.
    for (int t = 0; t < 60; t++) begin
      inst  = $urandom_range(0, 2);
      bytes = beats_of(inst) * 2;
      mode  = $urandom_range(0, 9);
      a = 32'd1024 + 32'(bytes * $urandom_range(0, 31));
      if (mode == 0)      a = a + 32'($urandom_range(1, bytes - 1));
      else if (mode == 1) a = a + 32'd524288;
      else if (mode == 2) a = 32'd1024 - 32'(bytes * $urandom_range(1, 8));
      op = $urandom_range(0, 3);
      d  = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) begin
        access(inst, op != 1, op != 0, a, d, 1);
        access(inst, 0, 1, a, 64'd0, 0);
      end else begin
        access(inst, op != 1 && op != 3, op != 0, a, d, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
